// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode 0 slave receiver front end.
// Synchronises raw SCLK/MOSI/CS_N into clk, deserialises MOSI into bytes and
// emits byte/frame events for the downstream command parser. clk must run at
// least 4x the SCLK frequency.
// Optional build macro SPI_RX_ECHO_EN: MISO echoes the previously received
// byte back to the host. Without it spi_miso is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_RESYNC | after reset; flush sync chains, wait for cs_n high
// S_IDLE   | no frame; waiting for a cs_n fall
// S_ACTIVE | inside a frame; shifting bits on synced sclk rises

module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,     // legal range 2..4
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic [7:0]  byte_recv,
    output logic        valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        partial,
    output logic [15:0] frame_bytes
);

    typedef enum logic [1:0] {
        S_RESYNC = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // Chains start at the pin idle values, so the first post-reset cycles look
    // like "cs_n high"; the flush count waits until real pin values have
    // reached both the sync output and the previous flop.
    localparam logic [2:0] FLUSH_INIT = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;

    state_t      state;
    logic [2:0]  flush_cnt;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;

    logic [2:0]  bit_cnt_nxt;
    logic [7:0]  shift_nxt;
    logic [2:0]  cnt_after;
    logic [15:0] frame_bytes_inc;

    // Pin synchronisers plus one previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Next shift/count values; cnt_after includes a same-cycle shift so that a
    // byte completed on the closing edge is not reported as partial.
    always_comb begin
        shift_nxt       = shift_q;
        bit_cnt_nxt     = bit_cnt_q + 3'd1;
        cnt_after       = bit_cnt_q;
        frame_bytes_inc = frame_bytes;
        if (MSB_FIRST) begin
            shift_nxt = {shift_q[6:0], mosi_s};
        end else begin
            shift_nxt = {mosi_s, shift_q[7:1]};
        end
        if (sclk_rise) begin
            cnt_after = bit_cnt_nxt;
        end
        if (frame_bytes != 16'hFFFF) begin
            frame_bytes_inc = frame_bytes + 16'd1;
        end
    end

    // Frame FSM with registered byte/event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESYNC;
            flush_cnt   <= FLUSH_INIT;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_recv   <= 8'd0;
            frame_bytes <= 16'd0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            partial     <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            partial     <= 1'b0;
            unique case (state)
                S_RESYNC: begin
                    if (flush_cnt != 3'd0) begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end else if (cs_s && cs_prev) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cs_fall) begin
                        state       <= S_ACTIVE;
                        frame_start <= 1'b1;
                        bit_cnt_q   <= 3'd0;
                        shift_q     <= 8'd0;
                        frame_bytes <= 16'd0;
                    end
                end
                S_ACTIVE: begin
                    if (sclk_rise) begin
                        shift_q   <= shift_nxt;
                        bit_cnt_q <= bit_cnt_nxt;
                        if (bit_cnt_q == 3'd7) begin
                            byte_recv   <= shift_nxt;
                            valid       <= 1'b1;
                            frame_bytes <= frame_bytes_inc;
                        end
                    end
                    if (cs_rise) begin
                        state     <= S_IDLE;
                        frame_end <= 1'b1;
                        partial   <= (cnt_after != 3'd0);
                    end
                end
                default: begin
                    state <= S_RESYNC;
                end
            endcase
        end
    end

`ifdef SPI_RX_ECHO_EN
    logic       sclk_fall;
    logic [7:0] echo_q;
    logic       miso_q;

    assign sclk_fall = ~sclk_s & sclk_prev;

    function automatic logic first_bit(input logic [7:0] v);
        return MSB_FIRST ? v[7] : v[0];
    endfunction

    function automatic logic [7:0] drop_bit(input logic [7:0] v);
        return MSB_FIRST ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
    endfunction

    // Echo shifter: a new byte starts on the first sclk fall after a byte
    // completes (bit count back at 0); byte 0 of a frame echoes the cleared
    // register, i.e. zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_q <= 8'd0;
            miso_q <= 1'b0;
        end else if (state == S_ACTIVE && !cs_rise) begin
            if (sclk_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    miso_q <= first_bit(byte_recv);
                    echo_q <= drop_bit(byte_recv);
                end else begin
                    miso_q <= first_bit(echo_q);
                    echo_q <= drop_bit(echo_q);
                end
            end
        end else begin
            echo_q <= 8'd0;
            miso_q <= 1'b0;
        end
    end

    assign spi_miso = miso_q;
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Bench for spi_byte_rx: two instances (MSB-first and LSB-first) share the
// same pins. A frame-level model predicts events from the bit stream and the
// pin-to-output latency; a compare process checks every cycle.
module tb_spi_byte_rx;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_cs_n = 1'b1;

    logic        miso_m, miso_l;
    logic [7:0]  br_m, br_l;
    logic        v_m, v_l, fs_m, fs_l, fe_m, fe_l, p_m, p_l;
    logic [15:0] fb_m, fb_l;

    always #5 clk = ~clk;

    spi_byte_rx #(.SYNC_STAGES(S), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(miso_m), .byte_recv(br_m), .valid(v_m),
        .frame_start(fs_m), .frame_end(fe_m), .partial(p_m), .frame_bytes(fb_m)
    );

    spi_byte_rx #(.SYNC_STAGES(S), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(miso_l), .byte_recv(br_l), .valid(v_l),
        .frame_start(fs_l), .frame_end(fe_l), .partial(p_l), .frame_bytes(fb_l)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    bit         in_frame = 1'b0;
    bit         armed    = 1'b0;
    bit         fbits[$];
    bit         ev_fs[int];
    logic [7:0] ev_vm[int];
    logic [7:0] ev_vl[int];
    bit         ev_fe[int];
    bit         ev_pt[int];
    logic [7:0] e_bm = 8'd0, e_bl = 8'd0;
    logic [15:0] e_fb = 16'd0;
    bit x_fs, x_v, x_fe, x_pt;

    // monitor of dut_m events, cleared per test
    int n_v = 0, n_fs = 0, n_fe = 0, n_pt = 0, n_vfe = 0;
    logic [7:0] got_q[$];
    logic cap_m[$];

    function automatic int key();
        return cyc + 1 + S;
    endfunction

    task automatic m_rise(input bit b);
        logic [7:0] bm, bl;
        int base;
        if (in_frame) begin
            fbits.push_back(b);
            if (fbits.size() % 8 == 0) begin
                base = fbits.size() - 8;
                bm = 8'd0;
                bl = 8'd0;
                for (int i = 0; i < 8; i++) begin
                    bm[7-i] = fbits[base+i];
                    bl[i]   = fbits[base+i];
                end
                ev_vm[key()] = bm;
                ev_vl[key()] = bl;
            end
        end
    endtask

    task automatic m_cs_fall();
        if (armed && !in_frame) begin
            in_frame = 1'b1;
            fbits.delete();
            ev_fs[key()] = 1'b1;
        end
    endtask

    task automatic m_cs_rise();
        if (in_frame) begin
            ev_fe[key()] = 1'b1;
            ev_pt[key()] = (fbits.size() % 8) != 0;
            in_frame = 1'b0;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            x_fs = 1'b0; x_v = 1'b0; x_fe = 1'b0; x_pt = 1'b0;
            if (rst) begin
                e_bm = 8'd0; e_bl = 8'd0; e_fb = 16'd0;
                ev_fs.delete(); ev_vm.delete(); ev_vl.delete();
                ev_fe.delete(); ev_pt.delete();
            end else begin
                x_fs = ev_fs.exists(cyc);
                x_v  = ev_vm.exists(cyc);
                x_fe = ev_fe.exists(cyc);
                if (x_fe) x_pt = ev_pt[cyc];
                if (x_fs) e_fb = 16'd0;
                if (x_v) begin
                    e_bm = ev_vm[cyc];
                    e_bl = ev_vl[cyc];
                    if (e_fb != 16'hFFFF) e_fb = e_fb + 16'd1;
                end
            end
            @(negedge clk);
            chk("valid_m", 32'(v_m), 32'(x_v));
            chk("valid_l", 32'(v_l), 32'(x_v));
            chk("fstart_m", 32'(fs_m), 32'(x_fs));
            chk("fstart_l", 32'(fs_l), 32'(x_fs));
            chk("fend_m", 32'(fe_m), 32'(x_fe));
            chk("fend_l", 32'(fe_l), 32'(x_fe));
            chk("partial_m", 32'(p_m), 32'(x_pt));
            chk("partial_l", 32'(p_l), 32'(x_pt));
            chk("byte_m", 32'(br_m), 32'(e_bm));
            chk("byte_l", 32'(br_l), 32'(e_bl));
            chk("fbytes_m", 32'(fb_m), 32'(e_fb));
            chk("fbytes_l", 32'(fb_l), 32'(e_fb));
            if (v_m === 1'b1) begin n_v++; got_q.push_back(br_m); end
            if (fs_m === 1'b1) n_fs++;
            if (fe_m === 1'b1) n_fe++;
            if (p_m === 1'b1 && fe_m === 1'b1) n_pt++;
            if (v_m === 1'b1 && fe_m === 1'b1) n_vfe++;
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        n_v = 0; n_fs = 0; n_fe = 0; n_pt = 0; n_vfe = 0;
        got_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_frame = 1'b0;
        armed = 1'b0;
        step(n);
        rst = 1'b0;
        if (spi_cs_n) begin
            step(10);
            armed = 1'b1;
        end
    endtask

    task automatic check_miso(input int half);
        bit exp;
        exp = 1'b0;
        if (in_frame) begin
`ifdef SPI_RX_ECHO_EN
            if (fbits.size() >= 8) exp = fbits[fbits.size()-8];
`endif
            cap_m.push_back(miso_m);
            if (half >= 4) begin
                chk("miso_m", 32'(miso_m), 32'(exp));
                chk("miso_l", 32'(miso_l), 32'(exp));
            end
        end
    endtask

    task automatic send_bit(input bit b, input int half, input bit cs_with);
        spi_mosi = b;
        step(half);
        check_miso(half);
        spi_sclk = 1'b1;
        m_rise(b);
        if (cs_with) begin
            spi_cs_n = 1'b1;
            m_cs_rise();
        end
        step(half);
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data, input int n, input bit lsbf,
                             input int half, input bit cs_on_last);
        for (int i = 0; i < n; i++) begin
            send_bit(lsbf ? data[i] : data[7-i], half, cs_on_last && (i == n - 1));
        end
    endtask

    task automatic run_frame(input logic [7:0] q[$], input bit lsbf, input int half,
                             input int extra, input bit collide);
        logic [7:0] tail;
        tail = 8'($urandom);
        spi_cs_n = 1'b0;
        m_cs_fall();
        step(2);
        for (int k = 0; k < q.size(); k++) begin
            send_bits(q[k], 8, lsbf, half, collide && extra == 0 && k == q.size() - 1);
        end
        if (extra > 0) send_bits(tail, extra, 1'b0, half, 1'b0);
        step(half);
        if (spi_cs_n == 1'b0) begin
            spi_cs_n = 1'b1;
            m_cs_rise();
        end
        step(8);
        armed = 1'b1;
        chk("miso_idle_m", 32'(miso_m), 32'd0);
        chk("miso_idle_l", 32'(miso_l), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] eb;
        logic [7:0] exp_basic[5];
        logic [7:0] exp_echo[3];
        int nb, half, extra;
        bit coll;

        exp_basic = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};

        do_reset(3);
        chk("rst_byte", 32'(br_m), 32'h00);
        chk("rst_fbytes", 32'(fb_m), 32'd0);
        chk("rst_miso", 32'(miso_m), 32'd0);

        // basic frame at clk/8
        clr_mon();
        q = {8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
        run_frame(q, 1'b0, 4, 0, 1'b0);
        chk("basic_fs", 32'(n_fs), 32'd1);
        chk("basic_nvalid", 32'(n_v), 32'd5);
        for (int i = 0; i < got_q.size() && i < 5; i++) chk("basic_byte", 32'(got_q[i]), 32'(exp_basic[i]));
        chk("basic_fe", 32'(n_fe), 32'd1);
        chk("basic_partial", 32'(n_pt), 32'd0);
        chk("basic_fbytes", 32'(fb_m), 32'd5);

        // bit order: stream 1,0,0,0,0,0,0,0
        clr_mon();
        q = {8'h01};
        run_frame(q, 1'b1, 4, 0, 1'b0);
        chk("order_lsb", 32'(br_l), 32'h01);
        chk("order_msb", 32'(br_m), 32'h80);

        // partial abort
        clr_mon();
        q = {8'hA5};
        run_frame(q, 1'b0, 4, 3, 1'b0);
        chk("part_nvalid", 32'(n_v), 32'd1);
        chk("part_fe", 32'(n_fe), 32'd1);
        chk("part_partial", 32'(n_pt), 32'd1);
        chk("part_byte", 32'(br_m), 32'hA5);
        chk("part_fbytes", 32'(fb_m), 32'd1);

        // reset mid-frame with CS_N held low
        spi_cs_n = 1'b0;
        m_cs_fall();
        step(2);
        send_bits(8'hF0, 3, 1'b0, 4, 1'b0);
        do_reset(3);
        clr_mon();
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 4, 1'b0);
        step(6);
        chk("rstmid_nvalid", 32'(n_v), 32'd0);
        chk("rstmid_nfs", 32'(n_fs), 32'd0);
        chk("rstmid_nfe", 32'(n_fe), 32'd0);
        spi_cs_n = 1'b1;
        m_cs_rise();
        step(8);
        armed = 1'b1;
        clr_mon();
        q = {8'h3C};
        run_frame(q, 1'b0, 4, 0, 1'b0);
        chk("rstmid_fs", 32'(n_fs), 32'd1);
        chk("rstmid_valid", 32'(n_v), 32'd1);
        chk("rstmid_byte", 32'(br_m), 32'h3C);

        // max rate with CS_N rising on the last SCLK rise
        clr_mon();
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(q, 1'b0, 2, 0, 1'b1);
        chk("max_nvalid", 32'(n_v), 32'd4);
        chk("max_valid_fe", 32'(n_vfe), 32'd1);
        chk("max_partial", 32'(n_pt), 32'd0);
        chk("max_byte", 32'(br_m), 32'hEF);

        // echo
        clr_mon();
        cap_m.delete();
        q = {8'h11, 8'h22, 8'h33};
        run_frame(q, 1'b0, 4, 0, 1'b0);
`ifdef SPI_RX_ECHO_EN
        exp_echo = '{8'h00, 8'h11, 8'h22};
`else
        exp_echo = '{8'h00, 8'h00, 8'h00};
`endif
        chk("echo_bits", 32'(cap_m.size()), 32'd24);
        for (int b = 0; b < 3 && cap_m.size() >= 24; b++) begin
            eb = 8'd0;
            for (int i = 0; i < 8; i++) eb[7-i] = cap_m[8*b+i];
            chk("echo_byte", 32'(eb), 32'(exp_echo[b]));
        end

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            q.delete();
            nb    = $urandom_range(0, 5);
            half  = $urandom_range(2, 6);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            coll  = (extra == 0) && (nb > 0) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
            run_frame(q, 1'($urandom), half, extra, coll);
            if (f == 12) do_reset(2);
        end

        step(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
